// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and helpers for the FIFO read arbiter.
// The ROUND_ROBIN_EN build macro switches the arbiter from fixed priority to rotating priority.
package fifo_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_PUSH  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_FIFOS = 4;
  localparam int unsigned DEF_WORD_SIZE = 6;

  // Ceiling log2; used to size the destination field and FIFO index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Handshake bundle between the arbiter and the input/output FIFO banks.
interface fifo_read_arbiter_if #(
  parameter int unsigned NUM_FIFOS = 4,
  parameter int unsigned WORD_SIZE = 6
);
  logic [NUM_FIFOS-1:0]           in_empty;
  logic [NUM_FIFOS*WORD_SIZE-1:0] in_data;
  logic [NUM_FIFOS-1:0]           out_almost_full;
  logic [NUM_FIFOS-1:0]           in_rd;
  logic [NUM_FIFOS-1:0]           out_wr;
  logic [WORD_SIZE-1:0]           out_data;
  logic                           paused;
  logic                           idle;
  logic                           error;

  modport master (
    input  in_empty, in_data, out_almost_full,
    output in_rd, out_wr, out_data, paused, idle, error
  );

  modport slave (
    output in_empty, in_data, out_almost_full,
    input  in_rd, out_wr, out_data, paused, idle, error
  );
endinterface

// File: rtl/fifo_read_arbiter_select.sv
// Combinational picker: first requesting index at or after i_start, wrapping around.
module fifo_arb_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    logic [IW-1:0] cand;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = '0;
    for (int k = 0; k < int'(N); k++) begin
      // N is a power of two, so IW-bit addition wraps modulo N
      cand = IW'(i_start + IW'(k));
      if (!o_valid && i_req[cand]) begin
        o_idx   = cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Drains the input FIFO bank and routes each word to the output FIFO named by its top bits.
// Build macro ROUND_ROBIN_EN selects rotating priority; default is lowest-index-first.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned DEST_L    = clog2(NUM_FIFOS)
) (
  input  logic               clk,
  input  logic               reset,
  fifo_read_arbiter_if.master bus
);

  state_t               r_state, w_state_nxt;
  logic [DEST_L-1:0]    r_grant, w_grant_nxt;
  logic [WORD_SIZE-1:0] r_hold, w_hold_nxt;
  logic [NUM_FIFOS-1:0] r_in_rd, w_in_rd_nxt;
  logic [NUM_FIFOS-1:0] r_out_wr, w_out_wr_nxt;
  logic                 r_paused, r_idle, r_error, w_error_nxt;

  logic [WORD_SIZE-1:0] w_words [NUM_FIFOS];
  logic [WORD_SIZE-1:0] w_pop_word;
  logic [DEST_L-1:0]    w_pop_dest;
  logic [DEST_L-1:0]    w_start;
  logic [DEST_L-1:0]    w_sel_idx;
  logic                 w_sel_valid;
  logic                 w_any_af;

  for (genvar gi = 0; gi < int'(NUM_FIFOS); gi++) begin : g_words
    assign w_words[gi] = bus.in_data[gi*WORD_SIZE +: WORD_SIZE];
  end

  assign w_pop_word = w_words[r_grant];
  assign w_pop_dest = w_pop_word[WORD_SIZE-1 -: DEST_L];
  assign w_any_af   = |bus.out_almost_full;

`ifdef ROUND_ROBIN_EN
  logic [DEST_L-1:0] r_last_grant;

  // Remember the most recent winner so the search starts just past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= DEST_L'(NUM_FIFOS - 1);
    end else if (w_state_nxt == ST_POP) begin
      r_last_grant <= w_grant_nxt;
    end
  end

  assign w_start = DEST_L'(r_last_grant + DEST_L'(1));
`else
  assign w_start = '0;
`endif

  fifo_arb_select #(
    .N  (NUM_FIFOS),
    .IW (DEST_L)
  ) u_select (
    .i_req   (~bus.in_empty),
    .i_start (w_start),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_hold_nxt   = r_hold;
    w_in_rd_nxt  = '0;
    w_out_wr_nxt = '0;
    w_error_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_PUSH: begin
        if (w_any_af) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_sel_valid) begin
          w_state_nxt = ST_POP;
          w_grant_nxt = w_sel_idx;
          w_in_rd_nxt = NUM_FIFOS'(1) << w_sel_idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_POP: begin
        if (!bus.in_empty[r_grant]) begin
          w_state_nxt  = ST_PUSH;
          w_hold_nxt   = w_pop_word;
          w_out_wr_nxt = NUM_FIFOS'(1) << w_pop_dest;
        end else begin
          w_state_nxt = ST_IDLE;
          w_error_nxt = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!w_any_af) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_hold   <= '0;
      r_in_rd  <= '0;
      r_out_wr <= '0;
      r_paused <= 1'b0;
      r_idle   <= 1'b1;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_hold   <= w_hold_nxt;
      r_in_rd  <= w_in_rd_nxt;
      r_out_wr <= w_out_wr_nxt;
      r_paused <= (w_state_nxt == ST_PAUSE);
      r_idle   <= (w_state_nxt == ST_IDLE);
      r_error  <= w_error_nxt;
    end
  end

  assign bus.in_rd    = r_in_rd;
  assign bus.out_wr   = r_out_wr;
  assign bus.out_data = r_hold;
  assign bus.paused   = r_paused;
  assign bus.idle     = r_idle;
  assign bus.error    = r_error;

endmodule
